text_data_bus_arbiter: RTL and testbench

Shares one synchronous single-port program/data memory between the instruction-fetch port and the load/store port of the core. Each cycle it grants at most one request, drives the memory's word address, write enables and write data, and returns read data one cycle later on the port that won. Fixed data priority with a starvation counter keeps fetch moving. Out-of-range and misaligned accesses get an error response instead of reaching the memory.

---
 rtl/text_data_bus_arbiter_if.sv | 47 ++++
 rtl/text_data_bus_arbiter.sv | 105 ++++++++++
 tb/tb_text_data_bus_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_data_bus_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// single-port program/data memory.
interface text_data_bus_arbiter_if #(
  parameter int MEM_WORD_BITS = 10
);
  logic                     fetch_req;
  logic [31:0]              fetch_address;
  logic                     fetch_gnt;
  logic                     fetch_rvalid;
  logic [31:0]              fetch_rdata;
  logic                     fetch_error;

  logic                     data_req;
  logic                     data_we;
  logic [3:0]               data_be;
  logic [31:0]              data_address;
  logic [31:0]              data_wdata;
  logic                     data_gnt;
  logic                     data_rvalid;
  logic [31:0]              data_rdata;
  logic                     data_error;

  logic [MEM_WORD_BITS-1:0] mem_address;
  logic                     mem_we;
  logic [3:0]               mem_be;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;

  // The arbiter side: takes requests and memory read data, drives the rest.
  modport slave (
    input  fetch_req, fetch_address,
    input  data_req, data_we, data_be, data_address, data_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_error,
    output data_gnt, data_rvalid, data_rdata, data_error,
    output mem_address, mem_we, mem_be, mem_wdata
  );

  modport master (
    output fetch_req, fetch_address,
    output data_req, data_we, data_be, data_address, data_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_error,
    input  data_gnt, data_rvalid, data_rdata, data_error,
    input  mem_address, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/text_data_bus_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// data has priority, a starvation counter forces fetch through periodically.
module text_data_bus_arbiter #(
  parameter logic [31:0] REGION_BEGIN  = 32'h0040_0000,
  parameter logic [31:0] REGION_END    = 32'h0040_0FFF,
  parameter int          MEM_WORD_BITS = 10,
  parameter int          STARVE_LIMIT  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  text_data_bus_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWNER_NONE, OWNER_FETCH, OWNER_DATA} owner_t;

  logic        armed;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  owner_t      winner;
  logic [31:0] win_address;
  logic        win_legal;
  logic        win_store;

  owner_t      resp_owner;
  logic        resp_valid;
  logic        resp_error;
  logic        resp_store;
  logic        fetch_resp;
  logic        data_resp;
  logic        read_ok;

  function automatic logic is_legal(input logic [31:0] a);
    return (a >= REGION_BEGIN) && (a <= REGION_END) && (a[1:0] == 2'b00);
  endfunction

  // Grants are held off until the first clock edge after reset release.
  always_comb begin
    winner      = OWNER_NONE;
    starve_next = 4'd0;
    if (armed) begin
      if (bus.fetch_req && bus.data_req)
        winner = (starve_cnt == LIMIT) ? OWNER_FETCH : OWNER_DATA;
      else if (bus.fetch_req)
        winner = OWNER_FETCH;
      else if (bus.data_req)
        winner = OWNER_DATA;
      if (bus.fetch_req && (winner != OWNER_FETCH))
        starve_next = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end
    win_address = (winner == OWNER_DATA) ? bus.data_address : bus.fetch_address;
    win_legal   = is_legal(win_address);
    win_store   = (winner == OWNER_DATA) && bus.data_we;
  end

  always_comb begin
    bus.fetch_gnt   = (winner == OWNER_FETCH);
    bus.data_gnt    = (winner == OWNER_DATA);
    bus.mem_address = '0;
    bus.mem_we      = 1'b0;
    bus.mem_be      = 4'b0000;
    bus.mem_wdata   = 32'h0;
    if ((winner != OWNER_NONE) && win_legal) begin
      bus.mem_address = win_address[MEM_WORD_BITS+1:2];
      if (win_store) begin
        bus.mem_we    = 1'b1;
        bus.mem_be    = bus.data_be;
        bus.mem_wdata = bus.data_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed      <= 1'b0;
      starve_cnt <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= OWNER_NONE;
      resp_error <= 1'b0;
      resp_store <= 1'b0;
    end else begin
      armed      <= 1'b1;
      starve_cnt <= starve_next;
      resp_valid <= (winner != OWNER_NONE);
      resp_owner <= winner;
      resp_error <= (winner != OWNER_NONE) && !win_legal;
      resp_store <= win_store;
    end
  end

  // Stores and errors are acknowledged with zero data; only legal reads pass memory data.
  always_comb begin
    fetch_resp       = resp_valid && (resp_owner == OWNER_FETCH);
    data_resp        = resp_valid && (resp_owner == OWNER_DATA);
    read_ok          = !resp_error && !resp_store;
    bus.fetch_rvalid = fetch_resp;
    bus.fetch_error  = fetch_resp && resp_error;
    bus.fetch_rdata  = (fetch_resp && read_ok) ? bus.mem_rdata : 32'h0;
    bus.data_rvalid  = data_resp;
    bus.data_error   = data_resp && resp_error;
    bus.data_rdata   = (data_resp && read_ok) ? bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_text_data_bus_arbiter.sv
// Randomized and directed bench for text_data_bus_arbiter against a
// transaction-level model of arbitration, memory contents and responses.
module tb_text_data_bus_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  text_data_bus_arbiter_if #(.MEM_WORD_BITS(10)) bus();

  text_data_bus_arbiter #(
    .REGION_BEGIN (32'h0040_0000),
    .REGION_END   (32'h0040_0FFF),
    .MEM_WORD_BITS(10),
    .STARVE_LIMIT (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];

  // Memory environment: synchronous single-port RAM with byte writes.
  always @(posedge clock) begin
    bus.mem_rdata <= tb_mem[bus.mem_address];
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) tb_mem[bus.mem_address][8*b +: 8] = bus.mem_wdata[8*b +: 8];
  end

  int          checks = 0;
  int          errors = 0;
  int          starve;
  logic        pend_valid, pend_data, pend_error;
  logic [31:0] pend_rdata;
  logic        last_f, last_d, obs_fgnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a >= 32'h0040_0000) && (a <= 32'h0040_0FFF) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return $urandom_range(0, 32'h003F_FFFF);
      1:       return 32'h0040_0000 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      2:       return 32'h0040_1000;
      3:       return 32'h0040_0FFC;
      default: return 32'h0040_0000 + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_fetch_gnt"},    32'(bus.fetch_gnt), 0);
    chk({tag, "_data_gnt"},     32'(bus.data_gnt), 0);
    chk({tag, "_fetch_rvalid"}, 32'(bus.fetch_rvalid), 0);
    chk({tag, "_data_rvalid"},  32'(bus.data_rvalid), 0);
    chk({tag, "_fetch_error"},  32'(bus.fetch_error), 0);
    chk({tag, "_data_error"},   32'(bus.data_error), 0);
    chk({tag, "_fetch_rdata"},  bus.fetch_rdata, 0);
    chk({tag, "_data_rdata"},   bus.data_rdata, 0);
    chk({tag, "_mem_we"},       32'(bus.mem_we), 0);
    chk({tag, "_mem_be"},       32'(bus.mem_be), 0);
    chk({tag, "_starve_cnt"},   32'(dut.starve_cnt), 0);
  endtask

  // One bus cycle: called just after a falling edge with inputs applied.
  task automatic applyStimulus();
    logic        ef, ed, any, lg, st;
    logic [31:0] a;
    int          w;
    #1;
    ef  = bus.fetch_req && (!bus.data_req || starve == 3);
    ed  = bus.data_req && !ef;
    any = ef || ed;
    a   = ed ? bus.data_address : bus.fetch_address;
    lg  = legal(a);
    st  = ed && bus.data_we;
    w   = lg ? int'((a - 32'h0040_0000) / 4) : 0;
    obs_fgnt = bus.fetch_gnt;
    chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(ef));
    chk("data_gnt",  32'(bus.data_gnt),  32'(ed));
    chk("mem_we",    32'(bus.mem_we),    32'(any && lg && st));
    chk("mem_be",    32'(bus.mem_be),    (any && lg && st) ? 32'(bus.data_be) : 0);
    if (any && lg) chk("mem_address", 32'(bus.mem_address), 32'(w));
    if (any && lg && st) chk("mem_wdata", bus.mem_wdata, bus.data_wdata);
    if (!any) begin
      chk("idle_mem_address", 32'(bus.mem_address), 0);
      chk("idle_mem_wdata",   bus.mem_wdata, 0);
    end
    chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(pend_valid && !pend_data));
    chk("data_rvalid",  32'(bus.data_rvalid),  32'(pend_valid && pend_data));
    chk("fetch_error",  32'(bus.fetch_error),  32'(pend_valid && !pend_data && pend_error));
    chk("data_error",   32'(bus.data_error),   32'(pend_valid && pend_data && pend_error));
    chk("fetch_rdata",  bus.fetch_rdata, (pend_valid && !pend_data) ? pend_rdata : 0);
    chk("data_rdata",   bus.data_rdata,  (pend_valid && pend_data) ? pend_rdata : 0);
    pend_valid = any;
    pend_data  = ed;
    pend_error = any && !lg;
    pend_rdata = (any && lg && !st) ? ref_mem[w] : 32'h0;
    if (any && lg && st)
      for (int b = 0; b < 4; b++)
        if (bus.data_be[b]) ref_mem[w][8*b +: 8] = bus.data_wdata[8*b +: 8];
    if (bus.fetch_req && !ef) starve = (starve == 3) ? 3 : starve + 1;
    else starve = 0;
    last_f = ef;
    last_d = ed;
    @(negedge clock);
  endtask

  task automatic set_fetch(input logic req, input logic [31:0] a);
    bus.fetch_req = req;
    bus.fetch_address = a;
  endtask

  task automatic set_data(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.data_req = req;
    bus.data_we = we;
    bus.data_be = be;
    bus.data_address = a;
    bus.data_wdata = wd;
  endtask

  task automatic clear_model();
    pend_valid = 1'b0;
    pend_data  = 1'b0;
    pend_error = 1'b0;
    pend_rdata = 32'h0;
    starve     = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[2]  = 32'h0000_0013;
    ref_mem[2] = 32'h0000_0013;
    bus.mem_rdata = 32'h0;
    clear_model();

    // Reset with both ports requesting: nothing may be granted.
    reset = 1'b0;
    set_fetch(1'b1, 32'h0040_0000);
    set_data(1'b1, 1'b1, 4'hF, 32'h0040_0004, 32'h1234_5678);
    @(negedge clock);
    #1 check_idle("in_reset");
    #2 reset = 1'b1;
    #1 check_idle("after_release");
    @(negedge clock);
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    set_fetch(1'b1, 32'h0040_0008);
    applyStimulus();
    set_fetch(1'b0, 32'h0);
    applyStimulus();
    chk("fetch_load_tb_mem", tb_mem[2], 32'h0000_0013);

    set_data(1'b1, 1'b1, 4'b0011, 32'h0040_0010, 32'hDEAD_BEEF);
    applyStimulus();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus();

    // Continuous contention: grant pattern D, D, D, F repeating.
    set_fetch(1'b1, 32'h0040_0010);
    set_data(1'b1, 1'b0, 4'h0, 32'h0040_0014, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      chk("starve_pattern", 32'(obs_fgnt), 32'(i % 4 == 3));
    end
    set_fetch(1'b0, 32'h0);

    set_data(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    applyStimulus();
    set_data(1'b1, 1'b1, 4'hF, 32'h0040_0002, 32'hFFFF_FFFF);
    applyStimulus();
    set_data(1'b1, 1'b0, 4'h0, 32'h0040_1000, 32'h0);
    applyStimulus();
    set_data(1'b1, 1'b0, 4'h0, 32'h003F_FFFC, 32'h0);
    applyStimulus();
    set_data(1'b1, 1'b0, 4'h0, 32'h0040_0FFC, 32'h0);
    applyStimulus();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus();

    // Reset during the response cycle of a fetch discards the response.
    set_fetch(1'b1, 32'h0040_0008);
    applyStimulus();
    set_fetch(1'b0, 32'h0);
    reset = 1'b0;
    #1 check_idle("reset_pending");
    #2 reset = 1'b1;
    set_data(1'b1, 1'b0, 4'h0, 32'h0040_0008, 32'h0);
    #1 check_idle("reset_pending_release");
    clear_model();
    @(negedge clock);
    applyStimulus();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus();

    for (int i = 0; i < 6; i++) begin
      set_fetch(i % 2 == 0, 32'h0040_0000 + 32'(4 * i));
      set_data(i % 2 == 1, 1'b0, 4'h0, 32'h0040_0040 + 32'(4 * i), 32'h0);
      applyStimulus();
    end
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus();

    // Random traffic; a request is held with the same payload until granted.
    for (int i = 0; i < 400; i++) begin
      if (!(bus.fetch_req && !last_f))
        set_fetch(($urandom % 4) != 0, rand_addr());
      if (!(bus.data_req && !last_d))
        set_data(($urandom % 3) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      applyStimulus();
    end
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
